// File: rtl/prefetch_pkg.sv
// Shared FSM state type and default widths for the instruction prefetch buffer.
package prefetch_pkg;
    typedef enum logic [1:0] {IDLE, FETCH, FLUSH} state_t;

    localparam int DEF_INSTR_W = 24;
    localparam int DEF_ADDR_W  = 16;
    localparam int DEF_DEPTH   = 4;
    localparam int DEF_MAX_OUT = 2;
endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO, power-of-two depth; a pushed word is visible at the head one cycle later.
// Push is accepted when full only together with a pop; flush wins over push and pop.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_dat,
    input  logic                     i_pop,
    input  logic                     i_flush,
    output logic [WIDTH-1:0]         o_dat,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_rd_ptr;
    logic [PW-1:0]    r_wr_ptr;
    logic [PW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == (PW+1)'(DEPTH));
    assign o_count   = r_count;
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            if (w_do_push && !w_do_pop)
                r_count <= r_count + (PW+1)'(1);
            else if (!w_do_push && w_do_pop)
                r_count <= r_count - (PW+1)'(1);
        end
    end

    // Storage carries no reset; the head is masked to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_dat;
    end

    assign o_dat = o_empty ? '0 : r_mem[r_rd_ptr];
endmodule

// File: rtl/instr_prefetch_buffer.sv
// Instruction prefetcher: issues in-order word fetches, buffers responses for decode (rvalid -> dec_valid 1 cycle).
// Requests only while buffered + outstanding < DEPTH; decode stalls simply stop new requests.
module instr_prefetch_buffer
    import prefetch_pkg::*;
#(
    parameter int INSTR_W = DEF_INSTR_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int MAX_OUT = DEF_MAX_OUT
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect_en,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               dec_valid,
    input  logic               dec_ready,
    output logic [INSTR_W-1:0] dec_instr,
    output logic [ADDR_W-1:0]  dec_pc
);
    localparam int CW = $clog2(DEPTH) + 1;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [ADDR_W-1:0]         r_pc;
    logic [CW-1:0]             r_out;
    logic [CW-1:0]             w_out_nxt;
    logic [CW-1:0]             w_fifo_count;
    logic [CW:0]               w_inflight;
    logic                      w_grant;
    logic                      w_rsp;
    logic                      w_push;
    logic                      w_pop;
    logic                      w_empty;
    logic                      w_full;
    logic [ADDR_W+INSTR_W-1:0] w_head;

    assign w_grant    = imem_req && imem_gnt;
    // A response with nothing outstanding is a protocol error and is ignored entirely.
    assign w_rsp      = imem_rvalid && (r_out != '0);
    assign w_pop      = dec_valid && dec_ready;
    assign w_push     = w_rsp && (r_state == FETCH) && !redirect_en && (!w_full || w_pop);
    assign w_inflight = {1'b0, w_fifo_count} + {1'b0, r_out};

    // Depends only on registered state, so decode backpressure never reaches imem_req combinationally.
    assign imem_req  = (r_state == FETCH) && (w_inflight < (CW+1)'(DEPTH)) && (r_out < CW'(MAX_OUT));
    assign imem_addr = r_pc;

    always_comb begin
        w_out_nxt = r_out;
        if (w_grant && !w_rsp)
            w_out_nxt = r_out + CW'(1);
        else if (!w_grant && w_rsp)
            w_out_nxt = r_out - CW'(1);
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    w_state_nxt = FETCH;
            FETCH:   w_state_nxt = FETCH;
            FLUSH:   if (w_out_nxt == '0) w_state_nxt = FETCH;
            default: w_state_nxt = IDLE;
        endcase
        if (redirect_en)
            w_state_nxt = (w_out_nxt != '0) ? FLUSH : FETCH;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_pc    <= '0;
            r_out   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_out   <= w_out_nxt;
            if (redirect_en)
                r_pc <= redirect_pc;
            else if (w_grant)
                r_pc <= r_pc + ADDR_W'(1);
        end
    end

    sync_fifo #(
        .WIDTH (ADDR_W + INSTR_W),
        .DEPTH (DEPTH)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_dat   ({r_pc - r_out, imem_rdata}),
        .i_pop   (w_pop),
        .i_flush (redirect_en),
        .o_dat   (w_head),
        .o_count (w_fifo_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign dec_valid           = !w_empty;
    assign {dec_pc, dec_instr} = w_head;
endmodule
